// File: rtl/show_draw_scheduler.sv
// Draw command sequencer: buffers CLEAR/RECT/CHAR commands and holds each one
// on the overlay engine's draw inputs for exactly as long as the engine needs.
module show_draw_scheduler #(
    parameter int A_W   = 7,
    parameter int L_W   = 8,
    parameter int DEPTH = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_type,
    input  logic [2:0]       cmd_color,
    input  logic [A_W-1:0]   cmd_ascii,
    input  logic [2*L_W-1:0] cmd_a,
    input  logic [2*L_W-1:0] cmd_b,
    output logic             busy,
    output logic             done,
    output logic [A_W-1:0]   o_ascii,
    output logic [2:0]       o_color,
    output logic [L_W-1:0]   o_ys,
    output logic [L_W-1:0]   o_ye,
    output logic [L_W-1:0]   o_x,
    output logic [L_W-1:0]   o_y,
    output logic [L_W-1:0]   o_x1,
    output logic [L_W-1:0]   o_y1,
    output logic [L_W-1:0]   o_x2,
    output logic [L_W-1:0]   o_y2
);
    localparam int AW  = $clog2(DEPTH);
    localparam int N_W = 2*L_W + 1;

    typedef struct packed {
        logic [1:0]       typ;
        logic [2:0]       color;
        logic [A_W-1:0]   ascii;
        logic [2*L_W-1:0] a;
        logic [2*L_W-1:0] b;
    } cmd_t;

    typedef struct packed {
        logic [A_W-1:0] ascii;
        logic [2:0]     color;
        logic [L_W-1:0] ys, ye, x, y, x1, y1, x2, y2;
    } out_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    cmd_t           r_mem [DEPTH];
    logic [AW:0]    r_wptr, r_rptr;
    cmd_t           r_ent;
    state_t         r_state, w_next;
    logic [N_W-1:0] r_cnt, r_len, w_len;
    out_t           r_out, w_run, w_idle;
    logic           w_full, w_empty, w_push, w_pop, w_drop, w_last, w_nowrite;
    logic [L_W-1:0] w_ahi, w_alo, w_bhi, w_blo;
    logic [L_W:0]   w_rows, w_sum;
    logic [L_W+2:0] w_perim;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push    = cmd_valid && !w_full;
    assign cmd_ready = !w_full;
    assign busy      = (r_state != S_IDLE) || !w_empty;
    assign done      = w_last;

    // Field split of the loaded command; a is {x1,y1}/{x,y}/{ys,ye}, b is {x2,y2}
    assign w_ahi = r_ent.a[2*L_W-1:L_W];
    assign w_alo = r_ent.a[L_W-1:0];
    assign w_bhi = r_ent.b[2*L_W-1:L_W];
    assign w_blo = r_ent.b[L_W-1:0];

    // Rows covered plus one extra row pass for the engine's column re-alignment
    assign w_rows  = {1'b0, w_alo} - {1'b0, w_ahi} + {{L_W{1'b0}}, 1'b1};
    // Rectangle outline length: 2*(dx+dy)+2 pixels
    assign w_sum   = {1'b0, w_bhi - w_ahi} + {1'b0, w_blo - w_alo};
    assign w_perim = {1'b0, w_sum, 1'b0} + {{(L_W+1){1'b0}}, 2'b10};
    assign w_nowrite = (r_ent.ascii == A_W'(0)) || (r_ent.ascii == A_W'(1)) ||
                       (r_ent.ascii == A_W'(32));

    // Hold length of the loaded command; zero means the command is dropped
    always_comb begin
        w_len = '0;
        case (r_ent.typ)
            2'd0:    if (w_ahi <= w_alo)
                         w_len = {w_rows, {L_W{1'b0}}} + {{L_W{1'b0}}, 1'b1, {L_W{1'b0}}};
            2'd1:    if (w_bhi >= w_ahi && w_blo >= w_alo) w_len = N_W'(w_perim);
            2'd2:    w_len = N_W'(8'd128);
            default: w_len = '0;
        endcase
    end
    assign w_drop = (r_ent.typ == 2'd3) || (w_len == '0);

    // Engine-facing values for the loaded command; unused coordinates park at 0
    always_comb begin
        w_idle       = '0;
        w_idle.ascii = A_W'(32);
        w_run        = '0;
        w_run.color  = r_ent.color;
        case (r_ent.typ)
            2'd0: begin
                w_run.ascii = '0;
                w_run.ys    = w_ahi;
                w_run.ye    = w_alo;
            end
            2'd1: begin
                w_run.ascii = A_W'(1);
                w_run.x1    = w_ahi;
                w_run.y1    = w_alo;
                w_run.x2    = w_bhi;
                w_run.y2    = w_blo;
            end
            default: begin
                w_run.ascii = w_nowrite ? A_W'(32) : r_ent.ascii;
                w_run.x     = w_ahi;
                w_run.y     = w_alo;
            end
        endcase
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next state, FIFO pop and done pulse
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        w_last = 1'b0;
        case (r_state)
            S_IDLE: if (!w_empty) begin
                w_pop  = 1'b1;
                w_next = S_LOAD;
            end
            S_LOAD: w_next = w_drop ? S_IDLE : S_RUN;
            S_RUN: if (r_cnt == r_len - {{(N_W-1){1'b0}}, 1'b1}) begin
                w_last = 1'b1;
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_LOAD;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FIFO storage, no reset needed since pointers gate its contents
    always_ff @(posedge sys_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= {cmd_type, cmd_color, cmd_ascii, cmd_a, cmd_b};
    end

    // Pointers, loaded entry, hold counter and registered engine outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ent  <= '0;
            r_cnt  <= '0;
            r_len  <= '0;
            r_out  <= w_idle;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_ent  <= r_mem[r_rptr[AW-1:0]];
                r_rptr <= r_rptr + 1'b1;
            end
            if (r_state == S_RUN) r_cnt <= r_cnt + 1'b1;
            if (r_state == S_LOAD && !w_drop) begin
                r_len <= w_len;
                r_cnt <= '0;
                r_out <= w_run;
            end
            if (w_next == S_IDLE) r_out <= w_idle;
        end
    end

    assign o_ascii = r_out.ascii;
    assign o_color = r_out.color;
    assign o_ys    = r_out.ys;
    assign o_ye    = r_out.ye;
    assign o_x     = r_out.x;
    assign o_y     = r_out.y;
    assign o_x1    = r_out.x1;
    assign o_y1    = r_out.y1;
    assign o_x2    = r_out.x2;
    assign o_y2    = r_out.y2;
endmodule

// File: tb/tb_show_draw_scheduler.sv
// Bench for show_draw_scheduler: command-queue timeline model plus literal pins.
module tb_show_draw_scheduler;
    localparam int A_W = 7, L_W = 8, DEPTH = 16;

    logic             sys_clk = 1'b0, sys_rst = 1'b1, cmd_valid = 1'b0;
    logic             cmd_ready, busy, done;
    logic [1:0]       cmd_type = '0;
    logic [2:0]       cmd_color = '0;
    logic [A_W-1:0]   cmd_ascii = '0;
    logic [2*L_W-1:0] cmd_a = '0, cmd_b = '0;
    logic [A_W-1:0]   o_ascii;
    logic [2:0]       o_color;
    logic [L_W-1:0]   o_ys, o_ye, o_x, o_y, o_x1, o_y1, o_x2, o_y2;

    show_draw_scheduler #(.A_W(A_W), .L_W(L_W), .DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_color(cmd_color), .cmd_ascii(cmd_ascii), .cmd_a(cmd_a),
        .cmd_b(cmd_b), .busy(busy), .done(done), .o_ascii(o_ascii), .o_color(o_color),
        .o_ys(o_ys), .o_ye(o_ye), .o_x(o_x), .o_y(o_y), .o_x1(o_x1), .o_y1(o_y1),
        .o_x2(o_x2), .o_y2(o_y2)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { int typ, color, ascii, ax, ay, bx, by; } mcmd_t;
    typedef struct packed {
        logic [A_W-1:0] ascii;
        logic [2:0]     color;
        logic [L_W-1:0] ys, ye, x, y, x1, y1, x2, y2;
    } outs_t;

    int n_err = 0, n_chk = 0;
    int done_cnt = 0, n65 = 0, nrect = 0, nclr = 0, acc_cnt = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycles the engine must see each command; 0 means dropped
    function automatic int n_of(mcmd_t c);
        case (c.typ)
            0:       return (c.ax > c.ay) ? 0 : (c.ay - c.ax + 1) * 256 + 256;
            1:       return (c.bx < c.ax || c.by < c.ay) ? 0 : 2 * ((c.bx - c.ax) + (c.by - c.ay)) + 2;
            2:       return 128;
            default: return 0;
        endcase
    endfunction

    function automatic outs_t idle_outs();
        outs_t o = '0;
        o.ascii = 7'd32;
        return o;
    endfunction

    function automatic outs_t outs_of(mcmd_t c);
        outs_t o = '0;
        o.color = 3'(c.color);
        case (c.typ)
            0: begin o.ascii = 7'd0; o.ys = 8'(c.ax); o.ye = 8'(c.ay); end
            1: begin
                o.ascii = 7'd1;
                o.x1 = 8'(c.ax); o.y1 = 8'(c.ay); o.x2 = 8'(c.bx); o.y2 = 8'(c.by);
            end
            default: begin
                o.ascii = (c.ascii == 0 || c.ascii == 1 || c.ascii == 32) ? 7'd32 : 7'(c.ascii);
                o.x = 8'(c.ax); o.y = 8'(c.ay);
            end
        endcase
        return o;
    endfunction

    // Model: queue of accepted commands; a command is fetched when the engine
    // frees up, shown one cycle later, then held for n_of() cycles.
    mcmd_t mq[$];
    mcmd_t pend, inc;
    bit    have_load = 0, m_on = 0, room;
    int    run_left = 0;
    outs_t m_out;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            mq.delete();
            run_left  = 0;
            have_load = 0;
            m_out     = idle_outs();
            m_on      = 1;
        end else if (m_on) begin
            room = (mq.size() < DEPTH);
            if (run_left > 1) begin
                run_left--;
            end else if (run_left == 1) begin
                run_left = 0;
                if (mq.size() > 0) begin pend = mq.pop_front(); have_load = 1; end
                else m_out = idle_outs();
            end else if (have_load) begin
                have_load = 0;
                if (n_of(pend) == 0) m_out = idle_outs();
                else begin m_out = outs_of(pend); run_left = n_of(pend); end
            end else if (mq.size() > 0) begin
                pend = mq.pop_front();
                have_load = 1;
            end
            if (cmd_valid && room) begin
                inc.typ = int'(cmd_type); inc.color = int'(cmd_color); inc.ascii = int'(cmd_ascii);
                inc.ax = int'(cmd_a[15:8]); inc.ay = int'(cmd_a[7:0]);
                inc.bx = int'(cmd_b[15:8]); inc.by = int'(cmd_b[7:0]);
                mq.push_back(inc);
                acc_cnt++;
            end
        end
    end

    // Compare every cycle away from the active edge
    always @(negedge sys_clk) begin
        if (m_on) begin
            chk("ready", cmd_ready, mq.size() < DEPTH);
            chk("busy", busy, (run_left > 0) || have_load || (mq.size() > 0));
            chk("done", done, run_left == 1);
            chk("outs", {o_ascii, o_color, o_ys, o_ye, o_x, o_y, o_x1, o_y1, o_x2, o_y2}, m_out);
        end
        if (!sys_rst) begin
            if (done) done_cnt++;
            if (o_ascii == 7'd65) n65++;
            if (o_ascii == 7'd1) nrect++;
            if (o_ascii == 7'd0) nclr++;
        end
    end

    task automatic send(int t, int col, int asc, int ax, int ay, int bx, int by);
        cmd_valid = 1'b1;
        cmd_type  = 2'(t);
        cmd_color = 3'(col);
        cmd_ascii = 7'(asc);
        cmd_a     = {8'(ax), 8'(ay)};
        cmd_b     = {8'(bx), 8'(by)};
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(string name, int lim);
        int k = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        while (busy && k < lim) begin
            @(posedge sys_clk); #1;
            k++;
        end
        chk(name, k >= lim, 0);
    endtask

    mcmd_t pin;
    int d0, a0, k;

    initial begin
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        // Model pins
        pin = '{1, 0, 0, 5, 5, 9, 7};   chk("pin_rect", n_of(pin), 14);
        pin = '{0, 0, 0, 0, 3, 0, 0};   chk("pin_clr", n_of(pin), 1280);
        pin = '{0, 0, 0, 4, 2, 0, 0};   chk("pin_clr_drop", n_of(pin), 0);

        // Idle after reset
        repeat (20) @(posedge sys_clk);
        #1;
        chk("t1_done", done_cnt, 0);
        chk("t1_ascii", o_ascii, 32);
        chk("t1_busy", busy, 0);
        chk("t1_ready", cmd_ready, 1);

        // CHAR 'A' at (10,20): two cycles to drive, 128 hold cycles
        send(2, 5, 65, 10, 20, 0, 0);
        @(posedge sys_clk); #1;
        chk("t2_lat_pre", o_ascii, 32);
        @(posedge sys_clk); #1;
        chk("t2_lat", {o_ascii, o_x, o_y}, {7'd65, 8'd10, 8'd20});
        drain("t2_drain", 400);
        chk("t2_hold", n65, 128);
        chk("t2_done", done_cnt, 1);

        // RECT valid, then reversed (dropped)
        send(1, 3, 0, 5, 5, 9, 7);
        drain("t3_drain", 200);
        chk("t3_hold", nrect, 14);
        chk("t3_done", done_cnt, 2);
        send(1, 3, 0, 9, 5, 5, 7);
        drain("t3b_drain", 200);
        chk("t3b_done", done_cnt, 2);
        chk("t3b_hold", nrect, 14);

        // CLEAR 0..3, then inverted band (dropped)
        send(0, 1, 0, 0, 3, 0, 0);
        drain("t4_drain", 3000);
        chk("t4_hold", nclr, 1280);
        chk("t4_done", done_cnt, 3);
        send(0, 1, 0, 4, 2, 0, 0);
        drain("t4b_drain", 200);
        chk("t4b_done", done_cnt, 3);

        // Non-writing glyph code runs full length; reserved type is discarded
        send(2, 2, 0, 3, 4, 0, 0);
        send(3, 2, 0, 0, 0, 0, 0);
        drain("t4c_drain", 400);
        chk("t4c_done", done_cnt, 4);

        // Fill the FIFO while a CHAR executes
        d0 = done_cnt; a0 = acc_cnt;
        send(2, 4, 66, 1, 1, 0, 0);
        repeat (5) @(posedge sys_clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            if (i % 2 == 0) send(1, i % 8, 0, i, i, i + 2, i + 1);
            else            send(2, i % 8, 33 + i, i, 2 * i, 0, 0);
        end
        chk("t5_full", cmd_ready, 0);
        chk("t5_acc", acc_cnt - a0, 17);
        drain("t5_drain", 6000);
        chk("t5_done", done_cnt - d0, acc_cnt - a0);
        chk("t5_done_lit", done_cnt - d0, 17);

        // Reset at count 50 of a CHAR with three queued
        d0 = done_cnt;
        send(2, 6, 67, 1, 2, 0, 0);
        send(2, 6, 68, 2, 2, 0, 0);
        send(2, 6, 69, 3, 2, 0, 0);
        send(2, 6, 70, 4, 2, 0, 0);
        k = 0;
        while (o_ascii != 7'd67 && k < 50) begin
            @(posedge sys_clk); #1;
            k++;
        end
        chk("t6_start", k >= 50, 0);
        repeat (50) @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_ascii", o_ascii, 32);
        chk("t6_ready", cmd_ready, 1);
        chk("t6_done", done_cnt, d0);
        repeat (10) @(posedge sys_clk);
        #1;
        chk("t6_stay_idle", {busy, o_ascii}, {1'b0, 7'd32});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
